// File: rtl/uba_intr_pkg.sv
// UBA interrupt block shared definitions.
// FSM states, timeout limit and bus-request bit positions.
package uba_intr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [5:0] TMO_LIMIT = 6'd63;

  localparam int BR7 = 3;
  localparam int BR6 = 2;
  localparam int BR5 = 1;
  localparam int BR4 = 0;

endpackage

// File: rtl/uba_intr_if.sv
// UBA interrupt block signal bundle.
// master drives requests/acks, slave is the interrupt block.
interface uba_intr_if;
  import uba_intr_pkg::*;

  logic [3:0]  devINTR;
  logic [17:0] devVECT;
  logic        devVECTVLD;
  logic [2:0]  regPIH;
  logic [2:0]  regPIL;
  logic        statINI;
  logic        ackREQ;
  logic [2:0]  ackPI;
  logic        statINTHI;
  logic        statINTLO;
  logic [6:0]  busINTR;
  logic [3:0]  devACK;
  logic        ackVALID;
  logic [17:0] busVECT;
  logic        busVECTVLD;
  logic        setTMO;

  modport master (
    output devINTR, devVECT, devVECTVLD,
    output regPIH, regPIL, statINI,
    output ackREQ, ackPI,
    input  statINTHI, statINTLO, busINTR,
    input  devACK, ackVALID,
    input  busVECT, busVECTVLD, setTMO
  );

  modport slave (
    input  devINTR, devVECT, devVECTVLD,
    input  regPIH, regPIL, statINI,
    input  ackREQ, ackPI,
    output statINTHI, statINTLO, busINTR,
    output devACK, ackVALID,
    output busVECT, busVECTVLD, setTMO
  );

endinterface

// File: rtl/uba_intr_prio.sv
// Grant selection for an interrupt acknowledge.
// HI level beats LO; within a level the higher BR wins.
module uba_intr_prio
  import uba_intr_pkg::*;
(
  input  logic [3:0] req,
  input  logic       statHi,
  input  logic       statLo,
  input  logic [2:0] regPIH,
  input  logic [2:0] regPIL,
  input  logic [2:0] ackPI,
  output logic [3:0] grant,
  output logic       hit
);

  logic hiOk;
  logic loOk;

  assign hiOk = statHi && (regPIH != 3'd0)
             && (ackPI == regPIH);
  assign loOk = statLo && (regPIL != 3'd0)
             && (ackPI == regPIL);

  // pick one-hot grant from the qualifying level
  always_comb begin
    grant = '0;
    hit   = 1'b0;
    unique case (1'b1)
      hiOk: begin
        hit = 1'b1;
        if (req[BR7]) grant[BR7] = 1'b1;
        else          grant[BR6] = 1'b1;
      end
      (!hiOk && loOk): begin
        hit = 1'b1;
        if (req[BR5]) grant[BR5] = 1'b1;
        else          grant[BR4] = 1'b1;
      end
      default: begin
        grant = '0;
        hit   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/uba_intr.sv
// UBA interrupt controller: status, PI requests,
// bus grant and vector return with timeout.
module uba_intr
  import uba_intr_pkg::*;
(
  input logic  clk,
  input logic  rst,
  uba_intr_if.slave bus
);

  state_t     state;
  state_t     stateNxt;
  logic [3:0] reqQ;
  logic [5:0] cnt;
  logic [3:0] grant;
  logic       hit;
  logic       grantLd;
  logic       vecLd;
  logic       tmoHit;
  logic [6:0] piVec;

  // status bits come from the sampled requests
  assign bus.statINTHI = reqQ[BR7] | reqQ[BR6];
  assign bus.statINTLO = reqQ[BR5] | reqQ[BR4];

  uba_intr_prio u_prio (
    .req    (reqQ),
    .statHi (bus.statINTHI),
    .statLo (bus.statINTLO),
    .regPIH (bus.regPIH),
    .regPIL (bus.regPIL),
    .ackPI  (bus.ackPI),
    .grant  (grant),
    .hit    (hit)
  );

  // map pending status onto the assigned PI levels
  always_comb begin
    piVec = '0;
    if (bus.statINTHI && bus.regPIH != 3'd0)
      piVec[bus.regPIH - 3'd1] = 1'b1;
    if (bus.statINTLO && bus.regPIL != 3'd0)
      piVec[bus.regPIL - 3'd1] = 1'b1;
  end

  // acknowledge FSM next state
  always_comb begin
    stateNxt = state;
    grantLd  = 1'b0;
    vecLd    = 1'b0;
    tmoHit   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ackREQ && hit) begin
          stateNxt = GRANT;
          grantLd  = 1'b1;
        end
      end
      GRANT: begin
        if (bus.devVECTVLD) begin
          vecLd    = 1'b1;
          stateNxt = DONE;
        end else if (cnt == TMO_LIMIT) begin
          tmoHit   = 1'b1;
          stateNxt = DONE;
        end
      end
      DONE: begin
        if (!bus.ackREQ) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // state register; initialize acts as sync reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              state <= IDLE;
    else if (bus.statINI) state <= IDLE;
    else                  state <= stateNxt;
  end

  // datapath registers and output pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reqQ           <= '0;
      cnt            <= '0;
      bus.busINTR    <= '0;
      bus.devACK     <= '0;
      bus.ackVALID   <= 1'b0;
      bus.busVECT    <= '0;
      bus.busVECTVLD <= 1'b0;
      bus.setTMO     <= 1'b0;
    end else if (bus.statINI) begin
      reqQ           <= '0;
      cnt            <= '0;
      bus.busINTR    <= '0;
      bus.devACK     <= '0;
      bus.ackVALID   <= 1'b0;
      bus.busVECT    <= '0;
      bus.busVECTVLD <= 1'b0;
      bus.setTMO     <= 1'b0;
    end else begin
      reqQ           <= bus.devINTR;
      bus.busINTR    <= piVec;
      bus.busVECTVLD <= 1'b0;
      bus.setTMO     <= 1'b0;
      if (grantLd) begin
        bus.devACK   <= grant;
        bus.ackVALID <= 1'b1;
        cnt          <= '0;
      end
      if (state == GRANT) begin
        cnt <= cnt + 6'd1;
        if (vecLd || tmoHit) begin
          bus.devACK     <= '0;
          bus.busVECTVLD <= 1'b1;
          bus.busVECT    <= vecLd ? bus.devVECT : '0;
          bus.setTMO     <= tmoHit;
        end
      end
      if (state == DONE && !bus.ackREQ)
        bus.ackVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uba_intr.sv
// Directed bench for uba_intr: status vectors,
// grant/vector/timeout and reset sequences.
module tb_uba_intr;

  logic clk;
  logic rst;
  int   nVec;
  int   nErr;

  uba_intr_if u_if ();

  uba_intr dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] intr;
    logic [2:0] pih;
    logic [2:0] pil;
    logic       hi;
    logic       lo;
    logic [6:0] pi;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] allOut();
    return {30'd0, u_if.statINTHI, u_if.statINTLO,
            u_if.busINTR, u_if.devACK, u_if.ackVALID,
            u_if.busVECT, u_if.busVECTVLD, u_if.setTMO};
  endfunction

  task automatic grantHi();
    u_if.regPIH  = 3'd3;
    u_if.regPIL  = 3'd5;
    u_if.devINTR = 4'b1000;
    tick(2);
    u_if.ackPI  = 3'd3;
    u_if.ackREQ = 1'b1;
    tick(1);
  endtask

  task automatic finishAck();
    u_if.ackREQ = 1'b0;
    tick(2);
  endtask

  initial begin
    nVec = 0;
    nErr = 0;
    tbl[0] = '{4'b0001, 3'd3, 3'd5, 1'b0, 1'b1, 7'b0010000};
    tbl[1] = '{4'b1000, 3'd3, 3'd5, 1'b1, 1'b0, 7'b0000100};
    tbl[2] = '{4'b0101, 3'd4, 3'd4, 1'b1, 1'b1, 7'b0001000};
    tbl[3] = '{4'b0011, 3'd3, 3'd0, 1'b0, 1'b1, 7'b0000000};
    tbl[4] = '{4'b1100, 3'd0, 3'd2, 1'b1, 1'b0, 7'b0000000};
    tbl[5] = '{4'b1111, 3'd7, 3'd1, 1'b1, 1'b1, 7'b1000001};
    tbl[6] = '{4'b0000, 3'd7, 3'd1, 1'b0, 1'b0, 7'b0000000};
    tbl[7] = '{4'b0110, 3'd2, 3'd6, 1'b1, 1'b1, 7'b0100010};

    u_if.devINTR    = '0;
    u_if.devVECT    = '0;
    u_if.devVECTVLD = 1'b0;
    u_if.regPIH     = '0;
    u_if.regPIL     = '0;
    u_if.statINI    = 1'b0;
    u_if.ackREQ     = 1'b0;
    u_if.ackPI      = '0;
    rst = 1'b1;
    #12;
    chk("reset_outs", allOut(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);

    // status latency: 1 cycle to stat, 2 to busINTR
    u_if.regPIH  = 3'd3;
    u_if.regPIL  = 3'd5;
    u_if.devINTR = 4'b0001;
    tick(1);
    chk("lat1_lo", u_if.statINTLO, 1'b1);
    chk("lat1_pi", u_if.busINTR, 7'b0000000);
    tick(1);
    chk("lat2_pi", u_if.busINTR, 7'b0010000);
    chk("lat2_hi", u_if.statINTHI, 1'b0);

    for (int i = 0; i < 8; i++) begin
      u_if.devINTR = tbl[i].intr;
      u_if.regPIH  = tbl[i].pih;
      u_if.regPIL  = tbl[i].pil;
      tick(2);
      chk($sformatf("v%0d_hi", i), u_if.statINTHI, tbl[i].hi);
      chk($sformatf("v%0d_lo", i), u_if.statINTLO, tbl[i].lo);
      chk($sformatf("v%0d_pi", i), u_if.busINTR, tbl[i].pi);
    end

    // vector return
    grantHi();
    chk("vr_ack", u_if.devACK, 4'b1000);
    tick(1);
    chk("vr_valid", u_if.ackVALID, 1'b1);
    tick(3);
    u_if.devVECT    = 18'o000120;
    u_if.devVECTVLD = 1'b1;
    tick(1);
    u_if.devVECTVLD = 1'b0;
    chk("vr_vect", u_if.busVECT, 18'o000120);
    chk("vr_vld", u_if.busVECTVLD, 1'b1);
    chk("vr_tmo", u_if.setTMO, 1'b0);
    chk("vr_ackdrop", u_if.devACK, 4'b0000);
    tick(1);
    chk("vr_pulse", u_if.busVECTVLD, 1'b0);
    chk("vr_done_valid", u_if.ackVALID, 1'b1);
    u_if.ackREQ = 1'b0;
    tick(1);
    chk("vr_idle_valid", u_if.ackVALID, 1'b0);
    tick(1);

    // timeout after 64 GRANT cycles
    grantHi();
    tick(63);
    chk("to_early_vld", u_if.busVECTVLD, 1'b0);
    chk("to_early_ack", u_if.devACK, 4'b1000);
    tick(1);
    chk("to_vld", u_if.busVECTVLD, 1'b1);
    chk("to_tmo", u_if.setTMO, 1'b1);
    chk("to_vect", u_if.busVECT, 18'd0);
    chk("to_ack", u_if.devACK, 4'b0000);
    tick(1);
    chk("to_pulse", {u_if.busVECTVLD, u_if.setTMO}, 2'b00);
    finishAck();

    // vector on the same cycle as count 63
    grantHi();
    tick(63);
    u_if.devVECT    = 18'o177001;
    u_if.devVECTVLD = 1'b1;
    tick(1);
    u_if.devVECTVLD = 1'b0;
    chk("race_vect", u_if.busVECT, 18'o177001);
    chk("race_vld", u_if.busVECTVLD, 1'b1);
    chk("race_tmo", u_if.setTMO, 1'b0);
    finishAck();

    // HI wins on shared level; wrong PI ignored
    u_if.regPIH  = 3'd4;
    u_if.regPIL  = 3'd4;
    u_if.devINTR = 4'b0101;
    tick(2);
    u_if.ackPI  = 3'd2;
    u_if.ackREQ = 1'b1;
    tick(2);
    chk("pi2_ack", u_if.devACK, 4'b0000);
    chk("pi2_valid", u_if.ackVALID, 1'b0);
    u_if.ackPI = 3'd4;
    tick(1);
    chk("hiwin_ack", u_if.devACK, 4'b0100);
    tick(2);

    // initialize mid-GRANT beats devVECTVLD
    u_if.statINI    = 1'b1;
    u_if.devVECT    = 18'o000777;
    u_if.devVECTVLD = 1'b1;
    tick(1);
    u_if.statINI    = 1'b0;
    u_if.devVECTVLD = 1'b0;
    u_if.ackREQ     = 1'b0;
    chk("ini_outs", allOut(), 64'd0);
    u_if.devVECTVLD = 1'b1;
    tick(1);
    u_if.devVECTVLD = 1'b0;
    chk("ini_idle_vld", u_if.busVECTVLD, 1'b0);
    chk("ini_idle_vect", u_if.busVECT, 18'd0);
    tick(1);

    // async reset mid-GRANT clears at once
    grantHi();
    tick(2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_outs", allOut(), 64'd0);
    u_if.ackREQ = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick(1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nVec, nErr);
    $finish;
  end

endmodule

// File: doc/uba_intr.md
UBA_INTR -- requirements
Module: uba_intr

Interface
REQ-001 Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
REQ-002 Device and register inputs:
- devINTR  in  4  bus requests, bit3=BR7 .. bit0=BR4, level-sensitive
- devVECT  in  18  interrupt vector from the granted device
- devVECTVLD  in  1  devVECT valid, single-cycle
- regPIH  in  3  high-level PI assignment (UBASR PIH); 0 = disabled
- regPIL  in  3  low-level PI assignment (UBASR PIL); 0 = disabled
- statINI  in  1  UBA initialize pulse
- ackREQ  in  1  CPU vector-read strobe, held until the cycle completes
- ackPI  in  3  PI level being acknowledged
REQ-003 Outputs:
- statINTHI  out  1  BR7|BR6 pending, to UBASR
- statINTLO  out  1  BR5|BR4 pending, to UBASR
- busINTR  out  7  PI request, bit n-1 = PI level n
- devACK  out  4  one-hot bus grant, bit3=BG7 .. bit0=BG4
- ackVALID  out  1  this UBA owns the current acknowledge
- busVECT  out  18  vector returned to the CPU
- busVECTVLD  out  1  busVECT valid, single-cycle pulse
- setTMO  out  1  vector timeout, single-cycle pulse, to UBASR

Function
REQ-004 statINTHI and statINTLO SHALL be registered ORs of devINTR[3:2] and devINTR[1:0], with one-cycle latency.
REQ-005 busINTR SHALL be registered from the current-cycle statINTHI and statINTLO.
- Bit (regPIH-1) is set when statINTHI=1 and regPIH≠0.
- Bit (regPIL-1) is set when statINTLO=1 and regPIL≠0.
- When regPIH=regPIL, the two requests OR into the same bit.
REQ-006 The FSM SHALL have states IDLE, GRANT and DONE.
REQ-007 In IDLE, with ackREQ=1:
- If ackPI=regPIH≠0 and statINTHI=1, the block grants the highest pending of BR7/BR6.
- Otherwise, if ackPI=regPIL≠0 and statINTLO=1, it grants the highest pending of BR5/BR4.
- HI wins whenever both qualify.
- If nothing qualifies, the FSM stays in IDLE with no response.
REQ-008 The granted level SHALL be latched on entry to GRANT.
- devACK holds the latched one-hot value throughout GRANT.
- A device dropping devINTR during GRANT does not abort the grant.
REQ-009 ackVALID SHALL assert on the cycle after GRANT entry and stay high until the DONE→IDLE transition.
REQ-010 A 6-bit timeout counter SHALL clear on GRANT entry and increment on each GRANT cycle.
REQ-011 In GRANT, devVECTVLD=1 SHALL:
- load busVECT with devVECT;
- pulse busVECTVLD for one cycle;
- drop devACK;
- move the FSM to DONE.
REQ-012 In GRANT, when the counter reaches 63 without devVECTVLD, the block SHALL:
- load busVECT with 0;
- pulse busVECTVLD and setTMO together for one cycle;
- drop devACK;
- move the FSM to DONE.
REQ-013 If devVECTVLD arrives on the same cycle as count 63, the vector SHALL win and setTMO SHALL stay low.
REQ-014 DONE SHALL return to IDLE on the first cycle with ackREQ=0.
REQ-015 ackREQ deasserting during GRANT SHALL NOT abort the grant; the FSM proceeds to DONE and then, with ackREQ=0, to IDLE one cycle later.
REQ-016 statINTHI, statINTLO and busINTR SHALL update every cycle in all FSM states.

Reset
REQ-017 On rst, all outputs SHALL be 0, the FSM SHALL be in IDLE and the counter SHALL be 0.
REQ-018 statINI=1 SHALL synchronously force the same state as rst, including mid-GRANT.
- It overrides devVECTVLD and timeout on the same cycle.
- No busVECTVLD or setTMO is emitted.

Structure
REQ-019 The FSM state enum, the timeout limit (63) and the BR bit positions SHALL live in the shared UBA package.
REQ-020 The grant-select priority logic (REQ-007) SHALL be one sub-module, uba_intr_prio, instantiated once.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Status path: regPIH=3, regPIL=5, devINTR=0001 → statINTLO=1 after 1 cycle, busINTR=0010000 after 2 cycles; statINTHI=0, busINTR bit 2 stays 0.
- Vector return: devINTR=1000, regPIH=3, ackREQ with ackPI=3 → devACK=1000, ackVALID=1; devVECTVLD with devVECT=0o000120 after 5 cycles → busVECT=0o000120, busVECTVLD pulse, no setTMO.
- Timeout: grant as above with no devVECTVLD → after 64 GRANT cycles busVECTVLD=1, setTMO=1, busVECT=0, devACK=0.
- HI wins: regPIH=regPIL=4, devINTR=0101 (BR6, BR4), ackPI=4 → devACK=0100; ackPI=2 → no response, FSM stays IDLE.
- Reset and initialize: statINI mid-GRANT on the same cycle as devVECTVLD → all outputs 0, FSM IDLE, no pulse; async rst mid-GRANT → outputs 0 immediately.
